// File: rtl/pwm_decoder_if.sv
// rtl/pwm_decoder_if.sv - signal bundle between a PWM line source and the decoder
//
// Purpose : groups the PWM input line and the decoded outputs so the decoder
//           and its environment connect through one port.
// Signals :
//   pwm_in      - single-wire PWM line (source drives, may be asynchronous)
//   code        - last decoded code
//   code_valid  - one-cycle strobe, code/period_err updated with it
//   period_err  - frame just decoded was not PERIOD clocks long
//   signal_lost - high while no frame timing is established
// Modports:
//   master - line source / consumer side (drives pwm_in)
//   slave  - decoder side (drives the decoded outputs)

interface pwm_decoder_if #(
   parameter int WIDTH = 8
);
   logic             pwm_in;
   logic [WIDTH-1:0] code;
   logic             code_valid;
   logic             period_err;
   logic             signal_lost;

   modport master (
      output pwm_in,
      input  code,
      input  code_valid,
      input  period_err,
      input  signal_lost
   );

   modport slave (
      input  pwm_in,
      output code,
      output code_valid,
      output period_err,
      output signal_lost
   );
endinterface

// File: rtl/pwm_decoder.sv
// rtl/pwm_decoder.sv - recovers the code from a single-wire PWM frame stream
//
// Purpose : measures the high time between consecutive rising edges of the
//           PWM line and reports code = high_clocks - 1 with a one-cycle
//           strobe at the start of the following frame. Flags frames whose
//           length differs from PERIOD and declares the line lost after
//           TIMEOUT clocks without a rising edge.
// Ports   :
//   clk    - system clock, all logic on the rising edge
//   rst_n  - synchronous active-low reset
//   bus    - pwm_decoder_if.slave: pwm_in in; code, code_valid,
//            period_err, signal_lost out (all registered)
// Params  :
//   WIDTH   - code width (PERIOD must equal 2**WIDTH)
//   PERIOD  - expected frame length in clocks
//   TIMEOUT - clocks without a rising edge before loss (> PERIOD)

module pwm_decoder #(
   parameter int WIDTH   = 8,
   parameter int PERIOD  = 256,
   parameter int TIMEOUT = 512
) (
   input  logic          clk,
   input  logic          rst_n,
   pwm_decoder_if.slave  bus
);

   localparam int CW = $clog2(TIMEOUT + 1);

   localparam logic [CW-1:0] C_ONE     = CW'(1);
   localparam logic [CW-1:0] C_PERIOD  = CW'(PERIOD);
   localparam logic [CW-1:0] C_TIMEOUT = CW'(TIMEOUT);
   localparam logic [CW-1:0] C_TO_M1   = CW'(TIMEOUT - 1);

   // synchroniser (r_s1, r_s2) and edge-detect delay (r_s3)
   logic             r_s1;
   logic             r_s2;
   logic             r_s3;

   logic [CW-1:0]    r_period_cnt;
   logic [CW-1:0]    r_high_cnt;
   logic             r_armed;

   logic [WIDTH-1:0] r_code;
   logic             r_code_valid;
   logic             r_period_err;
   logic             r_signal_lost;

   logic             w_rise;
   logic [WIDTH-1:0] w_code_meas;

   assign w_rise      = r_s2 & ~r_s3;
   // high_cnt never exceeds PERIOD, so high_cnt-1 always fits in WIDTH bits
   assign w_code_meas = WIDTH'(r_high_cnt - C_ONE);

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_s1          <= 1'b0;
         r_s2          <= 1'b0;
         r_s3          <= 1'b0;
         r_period_cnt  <= '0;
         r_high_cnt    <= '0;
         r_armed       <= 1'b0;
         r_code        <= '0;
         r_code_valid  <= 1'b0;
         r_period_err  <= 1'b0;
         r_signal_lost <= 1'b1;
      end else begin
         r_s1         <= bus.pwm_in;
         r_s2         <= r_s1;
         r_s3         <= r_s2;
         r_code_valid <= 1'b0;

         if (w_rise) begin
            // the rise cycle itself is the first high clock of the new frame
            r_period_cnt <= C_ONE;
            r_high_cnt   <= C_ONE;
            if (r_armed) begin
               r_code       <= w_code_meas;
               r_period_err <= (r_period_cnt != C_PERIOD);
               r_code_valid <= 1'b1;
            end else begin
               // first edge after reset/loss only establishes frame timing
               r_armed       <= 1'b1;
               r_signal_lost <= 1'b0;
            end
         end else begin
            if (r_period_cnt != C_TIMEOUT) begin
               r_period_cnt <= r_period_cnt + C_ONE;
            end
            if (r_s2 && (r_high_cnt != C_PERIOD)) begin
               r_high_cnt <= r_high_cnt + C_ONE;
            end
            // fires once on the way to saturation; a stuck-high line is a
            // continuous max-code stream, so report it as the top code
            if (r_period_cnt == C_TO_M1) begin
               r_armed       <= 1'b0;
               r_signal_lost <= 1'b1;
               if (r_s2) begin
                  r_code       <= '1;
                  r_period_err <= 1'b0;
                  r_code_valid <= 1'b1;
               end
            end
         end
      end
   end

   assign bus.code        = r_code;
   assign bus.code_valid  = r_code_valid;
   assign bus.period_err  = r_period_err;
   assign bus.signal_lost = r_signal_lost;

endmodule

// File: tb/tb_pwm_decoder.sv
// tb/tb_pwm_decoder.sv - scoreboard bench for pwm_decoder
//
// Purpose : drives directed PWM frames; each expected strobe (code, error,
//           cycle) is queued when its triggering rise is driven and a
//           separate monitor compares every code_valid strobe against it.

module tb_pwm_decoder;

   localparam int TIMEOUT = 512;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;

   always #5 clk = ~clk;

   pwm_decoder_if #(.WIDTH(8)) bus ();

   pwm_decoder #(
      .WIDTH   (8),
      .PERIOD  (256),
      .TIMEOUT (TIMEOUT)
   ) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus.slave)
   );

   typedef struct {
      logic [7:0] code;
      logic       err;
      int         cyc;
   } exp_t;

   exp_t sb[$];
   int   cyc    = 0;
   int   errors = 0;
   int   checks = 0;
   logic prev_valid = 1'b0;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic push(input int code, input bit err, input int at_cyc);
      exp_t e;
      e.code = code[7:0];
      e.err  = err;
      e.cyc  = at_cyc;
      sb.push_back(e);
   endtask

   // monitor: every strobe must match the head of the scoreboard
   always @(negedge clk) begin
      if (bus.code_valid === 1'b1) begin
         chk("strobe_width", int'(prev_valid), 0);
         if (sb.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_strobe: code %0d err %0d at cycle %0d, expected no strobe",
                     bus.code, bus.period_err, cyc);
         end else begin
            chk("code",       int'(bus.code),       int'(sb[0].code));
            chk("period_err", int'(bus.period_err), int'(sb[0].err));
            chk("strobe_cyc", cyc,                  sb[0].cyc);
            sb.delete(0);
         end
      end
      prev_valid <= bus.code_valid;
   end

   // One frame: high for 'high' clocks from the start, optional one-clock
   // glitch at 'glitch', optional one-clock reset at 'rstpos'. If exp_s, the
   // rise at the frame start must produce a strobe 3 negedges later.
   task automatic frame(input int high, input int len, input int glitch, input int rstpos,
                        input bit exp_s, input int exp_code, input bit exp_err);
      for (int i = 0; i < len; i++) begin
         @(negedge clk);
         if (i == 0 && exp_s) push(exp_code, exp_err, cyc + 3);
         if (i == glitch && exp_s) push(high - 1, 1'b1, cyc + 3);
         bus.pwm_in = (i < high) || (i == glitch);
         if (rstpos >= 0 && i == rstpos) rst_n = 1'b0;
         if (rstpos >= 0 && i == rstpos + 1) begin
            chk("mid_rst_code",  int'(bus.code),        0);
            chk("mid_rst_valid", int'(bus.code_valid),  0);
            chk("mid_rst_err",   int'(bus.period_err),  0);
            chk("mid_rst_lost",  int'(bus.signal_lost), 1);
            rst_n = 1'b1;
         end
      end
   endtask

   initial begin
      bus.pwm_in = 1'b0;
      repeat (3) @(negedge clk);
      chk("rst_code",  int'(bus.code),        0);
      chk("rst_valid", int'(bus.code_valid),  0);
      chk("rst_err",   int'(bus.period_err),  0);
      chk("rst_lost",  int'(bus.signal_lost), 1);
      rst_n = 1'b1;

      // code 100 stream: first rise only arms
      frame(101, 256, -1, -1, 1'b0, 0, 1'b0);
      chk("lost_after_arm", int'(bus.signal_lost), 0);
      frame(101, 256, -1, -1, 1'b1, 100, 1'b0);
      frame(101, 256, -1, -1, 1'b1, 100, 1'b0);

      // codes 0, 1, 127, 254
      frame(1,   256, -1, -1, 1'b1, 100, 1'b0);
      frame(2,   256, -1, -1, 1'b1, 0,   1'b0);
      frame(128, 256, -1, -1, 1'b1, 1,   1'b0);
      frame(255, 256, -1, -1, 1'b1, 127, 1'b0);

      // short frame: 200 clocks, 51 high
      frame(51,  200, -1, -1, 1'b1, 254, 1'b0);
      frame(101, 256, -1, -1, 1'b1, 50,  1'b1);

      // stuck high: normal strobe for last frame, then timeout strobe
      @(negedge clk);
      push(100, 1'b0, cyc + 3);
      push(255, 1'b0, cyc + TIMEOUT + 2);
      bus.pwm_in = 1'b1;
      repeat (599) @(negedge clk);
      chk("hi_lost", int'(bus.signal_lost), 1);
      chk("hi_code", int'(bus.code),        255);

      // stuck low: no strobe, code holds
      bus.pwm_in = 1'b0;
      repeat (600) @(negedge clk);
      chk("lo_lost", int'(bus.signal_lost), 1);
      chk("lo_code", int'(bus.code),        255);
      chk("lo_err",  int'(bus.period_err),  0);

      // code 200 stream with a one-clock reset in the low part of a frame
      frame(201, 256, -1, -1,  1'b0, 0,   1'b0);
      chk("rearm_lost", int'(bus.signal_lost), 0);
      frame(201, 256, -1, -1,  1'b1, 200, 1'b0);
      frame(201, 256, -1, 230, 1'b1, 200, 1'b0);
      frame(201, 256, -1, -1,  1'b0, 0,   1'b0);
      frame(11,  256, -1, -1,  1'b1, 200, 1'b0);

      // code 10 frame with a glitch at clock 40 splits into 10/err and 0/err
      frame(11, 256, 40, -1, 1'b1, 10, 1'b0);
      frame(11, 256, -1, -1, 1'b1, 0,  1'b1);
      frame(11, 256, -1, -1, 1'b1, 10, 1'b0);
      frame(11, 20,  -1, -1, 1'b1, 10, 1'b0);

      bus.pwm_in = 1'b0;
      repeat (10) @(negedge clk);
      chk("sb_drained", sb.size(), 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/pwm_decoder.md
Name: pwm_decoder

Overview:
- Receive-side counterpart of the team's 8-bit PWM generator. It recovers the 8-bit message code from a single-wire PWM stream.
- Each generator frame is PERIOD clocks long and is high for code+1 clocks starting at the frame start. The decoder measures the high time between consecutive rising edges and presents the code with a one-cycle valid strobe.
- It flags frames whose length is wrong and detects a stuck line. It sits at the far end of the PWM link, in the same clock domain or fed from an asynchronous pin.

Parameters:
- WIDTH, 8: code width in bits.
- PERIOD, 256: expected frame length in clocks; must equal 2**WIDTH.
- TIMEOUT, 512: clocks without a rising edge before the line is declared lost; must be greater than PERIOD.

Ports:
- clk, input, 1: system clock, all logic on rising edge.
- rst_n, input, 1: synchronous active-low reset.
- pwm_in, input, 1: PWM line, possibly asynchronous.
- code, output, WIDTH: last decoded code.
- code_valid, output, 1: one-cycle strobe; code and period_err are updated in the same cycle.
- period_err, output, 1: set if the frame just decoded was not PERIOD clocks long.
- signal_lost, output, 1: level; high while no frame timing is established.

Behaviour:
- Reset (rst_n=0 at a clk edge):
  - code=0, code_valid=0, period_err=0, signal_lost=1.
  - Synchroniser flops cleared, counters cleared, armed=0.
  - Reset mid-frame discards the partial measurement.
- Input path:
  - pwm_in passes through a 2-flop synchroniser (s1, s2), then a delay flop s3.
  - rise = s2 & ~s3.
- Counters:
  - period_cnt and high_cnt are each ceil(log2(TIMEOUT+1)) bits wide.
  - period_cnt saturates at TIMEOUT; high_cnt saturates at PERIOD.
- On a cycle with rise:
  - period_cnt<=1 and high_cnt<=1; the rise cycle counts as high.
  - If armed=1: code<=high_cnt-1, truncated to WIDTH; period_err<=(period_cnt!=PERIOD); code_valid<=1.
  - If armed=0: armed<=1 and signal_lost<=0; no strobe.
- On a cycle without rise:
  - period_cnt<=period_cnt+1 and high_cnt<=high_cnt+s2, both saturating.
  - code_valid<=0.
- Timeout, when period_cnt==TIMEOUT-1 and there is no rise:
  - armed<=0, signal_lost<=1.
  - If s2=1 (line stuck high, i.e. a continuous max-code stream): code<=2**WIDTH-1, period_err<=0, code_valid<=1 for one cycle.
  - If s2=0: no strobe, code holds.
  - While saturated at TIMEOUT no further strobes are issued.
- Latency:
  - If pwm_in is first sampled high at clk edge N, the corresponding code_valid is high from edge N+2 to edge N+3.
  - The strobe for a frame therefore appears at the start of the next frame.
  - The first frame after reset or after a loss only arms the decoder; the first strobe comes at the second rise.
- Boundary conditions:
  - A one-clock-wide high pulse decodes to code 0.
  - High for the whole frame with a 1-clock low gap decodes to 254.
  - A frame shorter or longer than PERIOD still yields code=high_cnt-1 with period_err=1.
  - high_cnt saturating at PERIOD decodes to 255.
- Glitches: a rising edge mid-frame splits the frame. Each part is decoded with period_err=1; no other filtering is done.
- Output registers: code and period_err hold between strobes. code_valid never stays high for two consecutive cycles.

Test Plan:
- Reset, then 3 frames of code 100 (101 high, 155 low): no strobe for the 1st rise; strobes at the 2nd and 3rd rises show code=100, period_err=0, signal_lost=0 after the 1st rise.
- Frames cycling through codes 0, 1, 127, 254: each strobe reports the previous frame's code exactly, period_err=0, strobe width 1 clock, at N+2 latency.
- Frame of 200 clocks with 51 high: code=50, period_err=1; a following 256-clock frame gives period_err=0.
- pwm_in held high 600 clocks after armed: signal_lost=1 and a single strobe with code=255 exactly TIMEOUT clocks after the last rise; no further strobes. Held low 600 clocks: signal_lost=1, no strobe, code holds.
- rst_n low for 1 clock mid-frame during a code-200 stream: outputs return to their reset values next cycle; the next rise only arms; the following strobe gives code=200.
- Single-clock glitch high at clock 40 of a code-10 frame: the split produces a strobe with period_err=1, then realignment; a clean frame afterwards gives code=10, period_err=0.
